// File: rtl/lane_note_engine.sv
// Per-lane falling-note engine: SLOTS concurrent notes, chart-driven spawns, hit-window scoring.
// Optional: define LANE_STRAY_PRESS_MISS_EN to count key presses outside the hit window as misses.
module lane_note_engine #(
    parameter int SLOTS    = 4,
    parameter int H_W      = 10,
    parameter int BEAT_W   = 7,
    parameter int SPAWN_Y  = 120,
    parameter int BOTTOM_Y = 720,
    parameter int STEP     = 1,
    parameter int HIT_LO   = 600,
    parameter int HIT_HI   = 680
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   pause,
    input  logic [BEAT_W-1:0]      beat_cnt,
    input  logic [2**BEAT_W-1:0]   spawn_map,
    input  logic                   key_in,
    output logic [SLOTS*H_W-1:0]   block_y,
    output logic [SLOTS-1:0]       block_vld,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic                   overflow,
    output logic [7:0]             hit_cnt,
    output logic [7:0]             miss_cnt
);

    localparam logic [H_W-1:0] SPAWN_POS  = H_W'(SPAWN_Y);
    localparam logic [H_W-1:0] BOTTOM_POS = H_W'(BOTTOM_Y);
    localparam logic [H_W-1:0] HIT_LO_POS = H_W'(HIT_LO);
    localparam logic [H_W-1:0] HIT_HI_POS = H_W'(HIT_HI);
    localparam logic [H_W:0]   BOTTOM_EXT = (H_W+1)'(BOTTOM_Y);
    localparam logic [H_W:0]   STEP_EXT   = (H_W+1)'(STEP);

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [H_W-1:0]    y_q [SLOTS];
    logic [H_W-1:0]    y_d [SLOTS];
    logic [SLOTS-1:0]  vld_q, vld_d;
    logic [BEAT_W-1:0] prev_beat_q;
    logic              key_d_q;
    logic              hit_pulse_q, hit_pulse_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        hit_cnt_q, hit_cnt_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;

    logic              spawn_req;
    logic              press;
    logic              hit_found;
    logic              stray;
    logic [SLOTS-1:0]  spawn_sel;
    logic [SLOTS-1:0]  hit_sel;
    logic [SLOTS-1:0]  exit_v;
    logic [H_W-1:0]    best_y;
    logic [H_W:0]      y_step [SLOTS];
    logic [3:0]        exit_cnt;
    logic [3:0]        miss_add;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        spawn_req = (beat_cnt > prev_beat_q) && spawn_map[beat_cnt] && !pause;
        press     = key_in && !key_d_q && !pause;

        // Lowest free slot, judged on this cycle's occupancy.
        spawn_sel = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                spawn_sel    = '0;
                spawn_sel[i] = 1'b1;
            end
        end

        // Deepest note in the window wins; strict '>' keeps ties on the lowest index.
        hit_sel   = '0;
        hit_found = 1'b0;
        best_y    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (vld_q[i] && y_q[i] >= HIT_LO_POS && y_q[i] <= HIT_HI_POS &&
                (!hit_found || y_q[i] > best_y)) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                best_y     = y_q[i];
                hit_found  = 1'b1;
            end
        end

        vld_d    = vld_q;
        exit_v   = '0;
        exit_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            y_d[i]    = y_q[i];
            y_step[i] = {1'b0, y_q[i]} + STEP_EXT;
            if (!pause) begin
                if (spawn_req && spawn_sel[i]) begin
                    vld_d[i] = 1'b1;
                    y_d[i]   = SPAWN_POS;
                end else if (press && hit_sel[i]) begin
                    vld_d[i] = 1'b0;
                    y_d[i]   = BOTTOM_POS;
                end else if (vld_q[i]) begin
                    if (y_step[i] >= BOTTOM_EXT) begin
                        vld_d[i]  = 1'b0;
                        y_d[i]    = BOTTOM_POS;
                        exit_v[i] = 1'b1;
                    end else begin
                        y_d[i] = y_step[i][H_W-1:0];
                    end
                end
            end
            exit_cnt = exit_cnt + {3'b000, exit_v[i]};
        end

`ifdef LANE_STRAY_PRESS_MISS_EN
        stray = press && !hit_found;
`else
        stray = 1'b0;
`endif

        miss_add     = exit_cnt + {3'b000, stray};
        hit_pulse_d  = press && hit_found;
        miss_pulse_d = (miss_add != 4'd0);
        overflow_d   = spawn_req && (&vld_q);
        hit_cnt_d    = hit_pulse_d ? sat_add(hit_cnt_q, 4'd1) : hit_cnt_q;
        miss_cnt_d   = sat_add(miss_cnt_q, miss_add);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the position array is reset like any register; it drives outputs and is only SLOTS entries.
            for (int i = 0; i < SLOTS; i++) y_q[i] <= BOTTOM_POS;
            vld_q        <= '0;
            prev_beat_q  <= '0;
            key_d_q      <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else if (restart) begin
            for (int i = 0; i < SLOTS; i++) y_q[i] <= BOTTOM_POS;
            vld_q        <= '0;
            prev_beat_q  <= '0;
            key_d_q      <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) y_q[i] <= y_d[i];
            vld_q        <= vld_d;
            prev_beat_q  <= beat_cnt;
            key_d_q      <= key_in;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            overflow_q   <= overflow_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_pack
        assign block_y[g*H_W +: H_W] = y_q[g];
    end

    assign block_vld  = vld_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign overflow   = overflow_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_lane_note_engine.sv
// Directed bench for lane_note_engine: vector table for spawn/pause/restart, hand sequences for hits, overflow, exits.
module tb_lane_note_engine;

    localparam int H_W = 10;
`ifdef LANE_STRAY_PRESS_MISS_EN
    localparam int STRAY = 1;
`else
    localparam int STRAY = 0;
`endif

    logic           clk;
    logic           rst_n;
    logic           restart;
    logic           pause;
    logic [6:0]     beat;
    logic [127:0]   spawn_map;
    logic           key_in;
    logic [39:0]    block_y;
    logic [3:0]     block_vld;
    logic           hit_pulse;
    logic           miss_pulse;
    logic           overflow;
    logic [7:0]     hit_cnt;
    logic [7:0]     miss_cnt;

    int errors = 0;
    int checks = 0;

    lane_note_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .pause      (pause),
        .beat_cnt   (beat),
        .spawn_map  (spawn_map),
        .key_in     (key_in),
        .block_y    (block_y),
        .block_vld  (block_vld),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .overflow   (overflow),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       restart;
        logic       pause;
        logic [6:0] beat;
        int         ticks;
        logic [3:0] vld;
        int         y0;
        int         y1;
        logic       ovf;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int slot_y(input int i);
        return int'(block_y[i*H_W +: H_W]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_restart();
        beat    = '0;
        key_in  = 1'b0;
        pause   = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        restart   = 1'b0;
        pause     = 1'b0;
        beat      = '0;
        spawn_map = '0;
        key_in    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        check("reset vld", block_vld, 0);
        for (int i = 0; i < 4; i++) check($sformatf("reset y%0d", i), slot_y(i), 720);
        check("reset hit_cnt", hit_cnt, 0);
        check("reset miss_cnt", miss_cnt, 0);
        check("reset pulses", {hit_pulse, miss_pulse, overflow}, 0);

        // restart, pause, beat, ticks, vld, y0, y1, ovf
        vecs[0] = '{1'b0, 1'b0, 7'd8,  1,  4'b0000, 720, 720, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 7'd9,  1,  4'b0001, 120, 720, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 7'd9,  5,  4'b0001, 125, 720, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 7'd15, 1,  4'b0011, 126, 120, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 7'd15, 10, 4'b0011, 126, 120, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 7'd20, 1,  4'b0011, 127, 121, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 7'd3,  1,  4'b0011, 128, 122, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 7'd9,  1,  4'b0111, 129, 123, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 7'd0,  1,  4'b0000, 720, 720, 1'b0};

        spawn_map[9]  = 1'b1;
        spawn_map[15] = 1'b1;
        for (int k = 0; k < NV; k++) begin
            restart = vecs[k].restart;
            pause   = vecs[k].pause;
            beat    = vecs[k].beat;
            tick(vecs[k].ticks);
            check($sformatf("vec%0d vld", k), block_vld, vecs[k].vld);
            check($sformatf("vec%0d y0", k), slot_y(0), vecs[k].y0);
            check($sformatf("vec%0d y1", k), slot_y(1), vecs[k].y1);
            check($sformatf("vec%0d ovf", k), overflow, vecs[k].ovf);
        end
        restart = 1'b0;
        pause   = 1'b0;

        // Overflow on the fifth spawn, then four exit-misses.
        do_restart();
        spawn_map = '0;
        spawn_map[5:1] = '1;
        for (int b = 1; b <= 4; b++) begin
            beat = 7'(b);
            tick(1);
        end
        check("ovf fill vld", block_vld, 4'b1111);
        check("ovf fill ovf", overflow, 0);
        beat = 7'd5;
        tick(1);
        check("ovf pulse", overflow, 1);
        check("ovf vld hold", block_vld, 4'b1111);
        check("ovf y0", slot_y(0), 124);
        tick(1);
        check("ovf pulse clear", overflow, 0);
        tick(594);
        check("exit pre y0", slot_y(0), 719);
        check("exit pre miss_cnt", miss_cnt, 0);
        tick(1);
        check("exit0 vld", block_vld, 4'b1110);
        check("exit0 y0", slot_y(0), 720);
        check("exit0 miss_pulse", miss_pulse, 1);
        check("exit0 miss_cnt", miss_cnt, 1);
        tick(3);
        check("exit all vld", block_vld, 0);
        check("exit all miss_cnt", miss_cnt, 4);
        tick(1);
        check("exit miss_pulse clear", miss_pulse, 0);

        // Single note hit at y=640, then asynchronous reset mid-game.
        do_restart();
        spawn_map = '0;
        spawn_map[9]  = 1'b1;
        spawn_map[10] = 1'b1;
        beat = 7'd9;
        tick(1);
        tick(520);
        check("hit640 pre y", slot_y(0), 640);
        key_in = 1'b1;
        tick(1);
        check("hit640 vld", block_vld, 0);
        check("hit640 y", slot_y(0), 720);
        check("hit640 pulse", hit_pulse, 1);
        check("hit640 hit_cnt", hit_cnt, 1);
        check("hit640 miss_pulse", miss_pulse, 0);
        key_in = 1'b0;
        tick(1);
        check("hit640 pulse clear", hit_pulse, 0);
        beat = 7'd10;
        tick(1);
        check("async pre vld", block_vld, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("async vld", block_vld, 0);
        check("async y0", slot_y(0), 720);
        check("async hit_cnt", hit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Window edges: 600 hits, 599 and 681 do not.
        do_restart();
        beat = 7'd9;
        tick(1);
        beat = 7'd10;
        tick(1);
        tick(479);
        check("edge pre y0", slot_y(0), 600);
        check("edge pre y1", slot_y(1), 599);
        key_in = 1'b1;
        tick(1);
        check("edge600 vld", block_vld, 4'b0010);
        check("edge600 hit", hit_pulse, 1);
        check("edge599 y1", slot_y(1), 600);
        check("edge600 miss_pulse", miss_pulse, 0);
        key_in = 1'b0;
        tick(81);
        check("edge681 pre y1", slot_y(1), 681);
        key_in = 1'b1;
        tick(1);
        check("edge681 vld", block_vld, 4'b0010);
        check("edge681 hit", hit_pulse, 0);
        check("edge681 stray miss_pulse", miss_pulse, STRAY);
        check("edge681 stray miss_cnt", miss_cnt, STRAY);
        key_in = 1'b0;
        tick(37);
        check("edge exit pre y1", slot_y(1), 719);
        tick(1);
        check("edge exit vld", block_vld, 0);
        check("edge exit miss_pulse", miss_pulse, 1);
        check("edge exit miss_cnt", miss_cnt, STRAY + 1);

        // Two notes at 650/610: deepest first; second hit at 680 coincides with a spawn.
        do_restart();
        spawn_map[11] = 1'b1;
        beat = 7'd9;
        tick(1);
        tick(39);
        beat = 7'd10;
        tick(1);
        tick(490);
        check("two pre y0", slot_y(0), 650);
        check("two pre y1", slot_y(1), 610);
        key_in = 1'b1;
        tick(1);
        check("two hit1 vld", block_vld, 4'b0010);
        check("two hit1 y0", slot_y(0), 720);
        check("two hit1 y1", slot_y(1), 611);
        check("two hit1 pulse", hit_pulse, 1);
        key_in = 1'b0;
        tick(69);
        check("two pre2 y1", slot_y(1), 680);
        key_in = 1'b1;
        beat   = 7'd11;
        tick(1);
        check("two hit2 vld", block_vld, 4'b0001);
        check("two hit2 spawn y0", slot_y(0), 120);
        check("two hit2 y1", slot_y(1), 720);
        check("two hit2 hit_cnt", hit_cnt, 2);
        key_in = 1'b0;

        // Hit and exit-miss in the same cycle.
        do_restart();
        beat = 7'd9;
        tick(1);
        tick(78);
        beat = 7'd10;
        tick(1);
        tick(520);
        check("dual pre y0", slot_y(0), 719);
        check("dual pre y1", slot_y(1), 640);
        key_in = 1'b1;
        tick(1);
        check("dual vld", block_vld, 0);
        check("dual pulses", {hit_pulse, miss_pulse}, 2'b11);
        check("dual hit_cnt", hit_cnt, 1);
        check("dual miss_cnt", miss_cnt, 1);
        key_in = 1'b0;

        // Pause over a spawn beat, key held through un-pause.
        do_restart();
        spawn_map = '0;
        spawn_map[9]  = 1'b1;
        spawn_map[12] = 1'b1;
        beat = 7'd9;
        tick(1);
        tick(180);
        check("pause pre y0", slot_y(0), 300);
        pause = 1'b1;
        tick(1);
        key_in = 1'b1;
        for (int b = 10; b <= 13; b++) begin
            beat = 7'(b);
            tick(1);
        end
        tick(45);
        check("pause y0", slot_y(0), 300);
        check("pause vld", block_vld, 4'b0001);
        check("pause ovf", overflow, 0);
        pause = 1'b0;
        tick(1);
        check("unpause y0", slot_y(0), 301);
        check("unpause vld", block_vld, 4'b0001);
        check("unpause no press", {hit_pulse, miss_pulse}, 0);
        key_in = 1'b0;

        // Stray press on an empty lane.
        do_restart();
        spawn_map = '0;
        key_in = 1'b1;
        tick(1);
        check("stray miss_pulse", miss_pulse, STRAY);
        check("stray miss_cnt", miss_cnt, STRAY);
        check("stray hit", hit_pulse, 0);
        key_in = 1'b0;

        // Continuous spawning until well over 255 exits.
        do_restart();
        spawn_map = '1;
        repeat (42000) begin
            beat = beat + 7'd1;
            tick(1);
        end
        check("sat miss_cnt", miss_cnt, 255);
        check("sat hit_cnt", hit_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_note_engine.md
Name: lane_note_engine

Overview:
- Multi-slot successor to the per-lane falling-block controllers. One instance per piano lane.
- Holds up to SLOTS simultaneous falling notes. Notes spawn on beat edges selected by a per-lane chart bitmap and advance every clk (clk_beat_ten domain).
- Resolves key presses against a hit window and keeps saturating hit/miss counts for the scoreboard.
- Sits between the beat counter and the VGA block renderer / score logic.

Parameters:
- SLOTS, 4, number of concurrent note slots (1..8).
- H_W, 10, width of a vertical position.
- BEAT_W, 7, width of beat_cnt; chart bitmap has 2**BEAT_W bits.
- SPAWN_Y, 120, y loaded on spawn.
- BOTTOM_Y, 720, idle/exit position.
- STEP, 1, pixels advanced per clk.
- HIT_LO, 600, lower bound of the hit window (inclusive).
- HIT_HI, 680, upper bound of the hit window (inclusive). Constraint: SPAWN_Y < HIT_LO <= HIT_HI < BOTTOM_Y - STEP.

Ports:
- clk  in  1  game tick clock.
- rst_n  in  1  reset, asynchronous, active-low.
- restart  in  1  synchronous clear, same effect as reset.
- pause  in  1  stop_or_endgame; freezes the lane.
- beat_cnt  in  BEAT_W  current beat number.
- spawn_map  in  2**BEAT_W  chart bitmap; bit b set spawns a note at beat b.
- key_in  in  1  debounced lane key level.
- block_y  out  SLOTS*H_W  packed slot positions; slot i at [i*H_W +: H_W].
- block_vld  out  SLOTS  slot occupied.
- hit_pulse  out  1  one-cycle pulse on a scored hit.
- miss_pulse  out  1  one-cycle pulse on a miss.
- overflow  out  1  one-cycle pulse when a spawn is dropped.
- hit_cnt  out  8  saturating hit count.
- miss_cnt  out  8  saturating miss count.

Behaviour:
- Reset / restart:
  - block_vld=0, every block_y=BOTTOM_Y.
  - All pulses 0, hit_cnt=miss_cnt=0.
  - prev_beat=0, key_d=0.
  - restart takes priority over every other event in the cycle.
- Beat edge:
  - beat_add = (beat_cnt > prev_beat). prev_beat <= beat_cnt every cycle, including while paused.
  - A beat wrap or hold therefore never spawns, and a beat that advances during pause does not spawn on un-pause.
- Spawn: when beat_add && spawn_map[beat_cnt] && !pause:
  - The lowest-index slot with vld=0 (evaluated on current-cycle vld) loads y=SPAWN_Y, vld=1 next cycle.
  - No free slot: spawn dropped, overflow=1 for one cycle.
  - A slot freed in the same cycle is not reusable until the next cycle.
- Motion (when !pause), for each valid slot not being spawned or hit:
  - If y+STEP >= BOTTOM_Y: vld<=0, y<=BOTTOM_Y, counts as an exit-miss.
  - Else y<=y+STEP.
  - Arithmetic is done in H_W+1 bits, so there is no wraparound.
- Key press: press = key_in & ~key_d. key_d is registered every cycle.
  - When press && !pause, candidate slots are valid slots with HIT_LO <= y <= HIT_HI (pre-motion value).
  - The candidate with the largest y wins; ties go to the lowest index. The winner is freed (vld<=0, y<=BOTTOM_Y) and hit_pulse=1.
  - No candidate: no effect (see optional feature).
  - Press while paused is ignored, but key_d still tracks, so holding through un-pause does not create a press.
- Simultaneous events:
  - Hit on one slot and exit-miss on another: both pulses in the same cycle; both counters update.
  - Multiple exit-misses in one cycle: miss_pulse=1, miss_cnt += number of exits (saturating).
  - Hit and spawn: both take effect; the spawn slot is chosen from pre-hit vld.
- Counters: hit_cnt and miss_cnt saturate at 255 and do not wrap.
- Pause: positions, vld and counters hold. Pulses are 0.
- Latency:
  - Spawn and hit are visible on outputs one clk after the triggering input cycle.
  - All outputs are registered.

Optional Feature:
- Macro: LANE_STRAY_PRESS_MISS_EN.
- Defined: a press with no candidate in the hit window (and !pause) asserts miss_pulse for one cycle and increments miss_cnt (saturating).
- Undefined: stray presses are ignored; misses come only from exits.

Test Plan:
- Defaults, spawn_map bits 9 and 15 set, beat_cnt stepped 8->9: 1 clk later block_vld=0001, slot0 y=120. At beat 15, slot1 y=120 while slot0 continues counting.
- Five spawn beats with no key presses and SLOTS=4: fifth spawn gives overflow=1 for 1 cycle and block_vld stays 1111. Each slot reaching 720 gives vld=0, miss_pulse, and miss_cnt increments to 4.
- Single note, key rising edge when y=640: next clk vld=0, y=720, hit_pulse=1, hit_cnt=1. Press at y=599 or y=681 gives no hit.
- Two notes at y=650 and y=610, one press: only the y=650 slot is freed; the second press hits the other.
- Pause asserted at y=300 for 50 clks while beat_cnt advances across a spawn beat: y stays 300, no spawn; after release y resumes at 301 with no burst spawn. Assert rst_n=0 mid-game: all outputs return to reset values immediately.
- LANE_STRAY_PRESS_MISS_EN defined, press with an empty window: miss_pulse=1, miss_cnt=1. Undefined: no pulse. 256 exits: miss_cnt holds at 255.
